// File: rtl/btn_pkg.sv
// Shared constants and types for the three-button selection front end.
// Button bit positions match the btn_db output ordering {CTRL, UP, DOWN}.
package btn_pkg;

    localparam int BTN_CTRL = 2;
    localparam int BTN_UP   = 1;
    localparam int BTN_DOWN = 0;

    typedef enum logic {
        ST_BROWSE = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

    // Bits needed to hold any value 0..max_val.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser followed by a stable-level debounce counter.
// rise is a one-cycle pulse in the first cycle the debounced level is high.
module btn_debounce
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 2_000_000
) (
    input  logic CLK,
    input  logic RST,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam int              CNT_W    = cnt_width(DEBOUNCE_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             level_q, level_d;
    logic             rise_q, rise_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d = raw;
        sync2_d = sync1_q;
        level_d = level_q;
        rise_d  = 1'b0;
        cnt_d   = cnt_q;
        if (sync2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            // Level held long enough: accept it and restart the count.
            level_d = ~level_q;
            rise_d  = ~level_q;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;

endmodule

// File: rtl/btn_select_ctrl.sv
// CTRL/UP/DOWN front end: debounced buttons drive a menu index with
// hold-to-repeat stepping and a CTRL-toggled lock.
module btn_select_ctrl
    import btn_pkg::*;
#(
    parameter int NUM_ITEMS        = 8,
    parameter int INIT_IDX         = 0,
    parameter int WRAP             = 1,
    parameter int DEBOUNCE_CYC     = 2_000_000,
    parameter int REPEAT_DELAY_CYC = 50_000_000,
    parameter int REPEAT_RATE_CYC  = 10_000_000,
    localparam int IDX_W           = $clog2(NUM_ITEMS)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CTRLbtn,
    input  logic             UPbtn,
    input  logic             DOWNbtn,
    output logic [IDX_W-1:0] sel_idx,
    output logic             locked,
    output logic             step_pulse,
    output logic             limit_pulse,
    output logic [2:0]       btn_db
);

    localparam int HOLD_MAX = (REPEAT_DELAY_CYC > REPEAT_RATE_CYC) ? REPEAT_DELAY_CYC
                                                                   : REPEAT_RATE_CYC;
    localparam int               HOLD_W    = cnt_width(HOLD_MAX);
    localparam logic [HOLD_W-1:0] DELAY_V  = HOLD_W'(REPEAT_DELAY_CYC);
    localparam logic [HOLD_W-1:0] RATE_V   = HOLD_W'(REPEAT_RATE_CYC);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_ITEMS - 1);
    localparam logic [IDX_W-1:0]  INIT_V   = IDX_W'(INIT_IDX);

    logic [2:0] raw_btn;
    logic [2:0] db_level;
    logic [2:0] db_rise;

    assign raw_btn = {CTRLbtn, UPbtn, DOWNbtn};

    for (genvar i = 0; i < 3; i++) begin : g_db
        btn_debounce #(
            .DEBOUNCE_CYC(DEBOUNCE_CYC)
        ) u_db (
            .CLK  (CLK),
            .RST  (RST),
            .raw  (raw_btn[i]),
            .level(db_level[i]),
            .rise (db_rise[i])
        );
    end

    // Hold counters for DOWN (0) and UP (1); rpt_q marks the post-delay phase.
    logic [1:0][HOLD_W-1:0] hold_q, hold_d;
    logic [1:0]             rpt_q, rpt_d;
    logic [1:0]             rep_fire;

    always_comb begin
        hold_d   = hold_q;
        rpt_d    = rpt_q;
        rep_fire = 2'b00;
        for (int i = 0; i < 2; i++) begin
            if (!db_level[i]) begin
                hold_d[i] = '0;
                rpt_d[i]  = 1'b0;
            end else if (hold_q[i] == (rpt_q[i] ? RATE_V : DELAY_V)) begin
                rep_fire[i] = 1'b1;
                hold_d[i]   = HOLD_W'(1);
                rpt_d[i]    = 1'b1;
            end else begin
                hold_d[i] = hold_q[i] + HOLD_W'(1);
            end
        end
    end

    logic step_up, step_dn, ctrl_press;

    assign step_up    = db_rise[BTN_UP]   | rep_fire[BTN_UP];
    assign step_dn    = db_rise[BTN_DOWN] | rep_fire[BTN_DOWN];
    assign ctrl_press = db_rise[BTN_CTRL];

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             step_q, step_d;
    logic             limit_q, limit_d;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        step_d  = 1'b0;
        limit_d = 1'b0;
        if (ctrl_press) begin
            // A CTRL press swallows any step arriving in the same cycle.
            state_d = (state_q == ST_BROWSE) ? ST_LOCKED : ST_BROWSE;
        end else if (state_q == ST_BROWSE && (step_up ^ step_dn)) begin
            if (step_up) begin
                if (idx_q == LAST_IDX) begin
                    if (WRAP != 0) begin
                        idx_d  = '0;
                        step_d = 1'b1;
                    end else begin
                        limit_d = 1'b1;
                    end
                end else begin
                    idx_d  = idx_q + IDX_W'(1);
                    step_d = 1'b1;
                end
            end else begin
                if (idx_q == '0) begin
                    if (WRAP != 0) begin
                        idx_d  = LAST_IDX;
                        step_d = 1'b1;
                    end else begin
                        limit_d = 1'b1;
                    end
                end else begin
                    idx_d  = idx_q - IDX_W'(1);
                    step_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            hold_q  <= '0;
            rpt_q   <= '0;
            state_q <= ST_BROWSE;
            idx_q   <= INIT_V;
            step_q  <= 1'b0;
            limit_q <= 1'b0;
        end else begin
            hold_q  <= hold_d;
            rpt_q   <= rpt_d;
            state_q <= state_d;
            idx_q   <= idx_d;
            step_q  <= step_d;
            limit_q <= limit_d;
        end
    end

    assign sel_idx     = idx_q;
    assign locked      = (state_q == ST_LOCKED);
    assign step_pulse  = step_q;
    assign limit_pulse = limit_q;
    assign btn_db      = db_level;

endmodule
